pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Controlling end of the PLL reset/locked interface: drives PLL rst, watches its locked output and
//  releases system reset only after lock has been continuously stable. Lives in the refclk domain
//  beside the PLL wrapper; retries lock on timeout, re-sequences on lock loss, latches a fault.
// PARAMETERS
//  PLL_RST_CYCLES      50     refclk cycles pll_rst is held high per reset pulse (1 us @ 50 MHz)
//  LOCK_STABLE_CYCLES  1024   consecutive synced-locked cycles required before sys_rst_n release
//  LOCK_TIMEOUT_CYCLES 50000  max cycles from pll_rst release to RUN before a retry (1 ms)
//  MAX_RETRIES         3      timeouts tolerated before FAULT
//  SYNC_STAGES         2      flops in locked synchronizer (>=2)
// PORTS
//  refclk          in   1  free-running reference clock (50 MHz), sole clock
//  rst             in   1  asynchronous, active-low reset
//  locked          in   1  PLL locked, asynchronous to refclk
//  soft_reset_req  in   1  single-cycle request to re-sequence the PLL
//  pll_rst         out  1  active-high reset to PLL
//  sys_rst_n       out  1  active-low system reset, low until lock stable
//  fault           out  1  sticky: retries exhausted
//  state_o         out  3  current FSM state (encoding from package)
//  retry_cnt       out  $clog2(MAX_RETRIES+1)  timeouts in current attempt
//  lock_lost_cnt   out  8  lock losses while in RUN, saturates at 255
// BEHAVIOUR
//  - Reset (rst=0, async): state=PLL_RST, pll_rst=1, sys_rst_n=0, fault=0, all counters 0.
//  - locked passes through SYNC_STAGES flops -> locked_s; all decisions use locked_s only.
//  - All outputs registered; decoded from next state so they change on the transition edge.
//  - PLL_RST: pll_rst=1; after PLL_RST_CYCLES -> WAIT_LOCK, clear timeout timer.
//  - WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE (stable cnt=0).
//  - STABLE: stable cnt++ while locked_s=1; reaches LOCK_STABLE_CYCLES -> RUN, sys_rst_n=1,
//    retry_cnt=0. locked_s=0 -> WAIT_LOCK, stable cnt cleared, timeout timer NOT cleared.
//  - Timeout timer runs in WAIT_LOCK and STABLE; at LOCK_TIMEOUT_CYCLES: retry_cnt==MAX_RETRIES ->
//    FAULT, else retry_cnt++ and -> PLL_RST.
//  - RUN: locked_s=0 -> PLL_RST, sys_rst_n=0 same edge, lock_lost_cnt++ (sat 255).
//  - FAULT: pll_rst=1, sys_rst_n=0, fault=1; left only via soft_reset_req.
//  - soft_reset_req (any state) -> PLL_RST, retry_cnt=0, fault=0; lock_lost_cnt unchanged.
//    Priority: rst > soft_reset_req > timeout > locked_s events.
//  - Timeout and stable-complete on same cycle: stable-complete wins (-> RUN).
//  - Counters sized $clog2(max+1); no wrap, compare with ==.
// STRUCTURE
//  - pll_sup_pkg: state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} with 3-bit encoding,
//    LOST_CNT_W=8 constant.
//  - Sub-module bit_sync (SYNC_STAGES flops, async active-low reset to 0) for locked.
//  - Main module: FSM + timeout, stable, pll_rst, retry, lost counters.
// TESTING (bench params: PLL_RST=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2, SYNC=2)
//  1 Release rst, raise locked 10 cycles later, hold -> pll_rst high exactly 4 cycles;
//    sys_rst_n rises SYNC+STABLE+1=11 cycles after locked rises; state_o=RUN.
//  2 locked held 0 -> 3 pll_rst pulses of 4 cycles spaced 36 cycles; then fault=1,
//    retry_cnt=2, state FAULT, pll_rst=1.
//  3 In STABLE drop locked 3 cycles then restore -> back to WAIT_LOCK, stable count restarts,
//    sys_rst_n stays 0, RUN reached only via fresh 8-cycle window (or timeout retry if late).
//  4 In RUN drop locked -> sys_rst_n=0 within SYNC+1 cycles, 4-cycle pll_rst pulse,
//    lock_lost_cnt=1; repeat 260 losses -> lock_lost_cnt=255.
//  5 In FAULT pulse soft_reset_req -> next edge fault=0, retry_cnt=0, pll_rst pulse restarts.
//  6 Assert rst mid-STABLE and mid-PLL_RST -> outputs at reset values before next refclk edge.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared types and constants for the PLL lock supervisor.
//               The state encoding is fixed at 3 bits because it is
//               exported on state_o.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int LOST_CNT_W = 8;
    localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

endpackage : pll_sup_pkg
`default_nettype wire

// File: rtl/pll_lock_supervisor_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Multi-flop synchronizer for a single asynchronous level.
//               All stages clear to 0 on reset, so an unsynchronized "1"
//               is never reported straight out of reset.
// Ports       : clk_i  - destination clock
//               rst_ni - asynchronous active-low reset
//               d_i    - asynchronous input level
//               q_o    - synchronized level (STAGES cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Drives the PLL reset, watches the (asynchronous) locked
//               indication and releases the system reset only after lock
//               has been continuously stable. Retries on lock timeout,
//               re-sequences on lock loss and latches a fault once the
//               retries are exhausted.
// Ports       : refclk         - reference clock, sole clock
//               rst            - asynchronous active-low reset
//               locked         - PLL locked, asynchronous to refclk
//               soft_reset_req - single-cycle request to re-sequence
//               pll_rst        - active-high PLL reset
//               sys_rst_n      - active-low system reset
//               fault          - retries exhausted (held until soft reset)
//               state_o        - current FSM state
//               retry_cnt      - timeouts in the current attempt
//               lock_lost_cnt  - lock losses in RUN, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 50,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 locked,
    input  logic                                 soft_reset_req,
    output logic                                 pll_rst,
    output logic                                 sys_rst_n,
    output logic                                 fault,
    output logic [2:0]                           state_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
    output logic [LOST_CNT_W-1:0]                lock_lost_cnt
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    // Terminal values: each counter starts at 0 on entry, so the last
    // cycle of a window is reached when the counter equals N-1.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic                  locked_s;
    pll_state_e            state_q,     state_d;
    logic [RST_W-1:0]      rst_cnt_q,   rst_cnt_d;
    logic [STB_W-1:0]      stable_q,    stable_d;
    logic [TMO_W-1:0]      tmo_q,       tmo_d;
    logic [RTY_W-1:0]      retry_q,     retry_d;
    logic [LOST_CNT_W-1:0] lost_q,      lost_d;
    logic                  pll_rst_q,   pll_rst_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  fault_q,     fault_d;
    logic                  tmo_hit;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk_i  (refclk),
        .rst_ni (rst),
        .d_i    (locked),
        .q_o    (locked_s)
    );

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= PLL_RST;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fault_q     <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Priority: soft_reset_req > timeout > locked_s events, except that a
    // stable window completing on the timeout cycle still goes to RUN.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        lost_d    = lost_q;
        tmo_hit   = (tmo_q == TMO_LAST);

        if (soft_reset_req) begin
            state_d   = PLL_RST;
            rst_cnt_d = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d  = WAIT_LOCK;
                        tmo_d    = '0;
                        stable_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end

                WAIT_LOCK, STABLE: begin
                    // The timeout covers the whole pll_rst-release-to-RUN
                    // window, so it keeps running across STABLE->WAIT_LOCK.
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == STABLE && locked_s && stable_q == STB_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else if (tmo_hit) begin
                        if (retry_q == RTY_MAX) begin
                            state_d = FAULT;
                        end else begin
                            state_d   = PLL_RST;
                            rst_cnt_d = '0;
                            retry_d   = retry_q + 1'b1;
                        end
                    end else if (!locked_s) begin
                        state_d  = WAIT_LOCK;
                        stable_d = '0;
                    end else if (state_q == WAIT_LOCK) begin
                        state_d  = STABLE;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end

                RUN: begin
                    if (!locked_s) begin
                        state_d   = PLL_RST;
                        rst_cnt_d = '0;
                        if (lost_q != LOST_CNT_MAX) begin
                            lost_d = lost_q + 1'b1;
                        end
                    end
                end

                FAULT: begin
                    state_d = FAULT;
                end

                default: begin
                    state_d   = PLL_RST;
                    rst_cnt_d = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they switch on the
        // same edge as the transition.
        pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
        sys_rst_n_d = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign fault         = fault_q;
    assign state_o       = state_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule : pll_lock_supervisor
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor. A timeline
//               model (phase, age in phase, age of the lock window, run
//               length of synchronized lock samples) predicts the outputs
//               after every refclk edge; a monitor compares on the falling
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int P_RST  = 4;
    localparam int P_STB  = 8;
    localparam int P_TMO  = 32;
    localparam int P_MAXR = 2;
    localparam int P_SYNC = 2;
    localparam int RW     = $clog2(P_MAXR + 1);

    logic                  refclk = 1'b0;
    logic                  rst    = 1'b0;
    logic                  locked = 1'b0;
    logic                  soft_reset_req = 1'b0;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  fault;
    logic [2:0]            state_o;
    logic [RW-1:0]         retry_cnt;
    logic [LOST_CNT_W-1:0] lock_lost_cnt;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TMO),
        .MAX_RETRIES         (P_MAXR),
        .SYNC_STAGES         (P_SYNC)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .sys_rst_n      (sys_rst_n),
        .fault          (fault),
        .state_o        (state_o),
        .retry_cnt      (retry_cnt),
        .lock_lost_cnt  (lock_lost_cnt)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic          pr;
        logic          sr;
        logic          f;
        logic [RW-1:0] rc;
        logic [7:0]    lc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    pll_state_e m_ph;
    int m_age;      // cycles spent in the pll_rst pulse
    int m_win;      // cycles since pll_rst release
    int m_run;      // consecutive synchronized-high samples in the window
    int m_retry;
    int m_lost;
    int hist[$];    // raw locked samples, newest first

    function automatic void model_reset();
        m_ph = PLL_RST; m_age = 0; m_win = 0; m_run = 0;
        m_retry = 0; m_lost = 0;
        hist.delete();
        for (int i = 0; i <= P_SYNC; i++) hist.push_back(0);
    endfunction

    function automatic void model_edge(input logic lk, input logic sr);
        int ls;
        hist.push_front(int'(lk));
        void'(hist.pop_back());
        ls = hist[P_SYNC];   // what the FSM sees in front of this edge
        if (sr) begin
            m_ph = PLL_RST; m_age = 0; m_retry = 0;
        end else begin
            case (m_ph)
                PLL_RST: begin
                    m_age++;
                    if (m_age == P_RST) begin
                        m_ph = WAIT_LOCK; m_win = 0; m_run = 0;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    m_win++;
                    m_run = (ls != 0) ? m_run + 1 : 0;
                    // first high sample enters STABLE, then P_STB more
                    if (m_run == P_STB + 1) begin
                        m_ph = RUN; m_retry = 0;
                    end else if (m_win == P_TMO) begin
                        if (m_retry == P_MAXR) m_ph = FAULT;
                        else begin m_retry++; m_ph = PLL_RST; m_age = 0; end
                    end else begin
                        m_ph = (m_run > 0) ? STABLE : WAIT_LOCK;
                    end
                end
                RUN: begin
                    if (ls == 0) begin
                        m_ph = PLL_RST; m_age = 0;
                        if (m_lost < 255) m_lost++;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st = m_ph;
        e.pr = (m_ph == PLL_RST) || (m_ph == FAULT);
        e.sr = (m_ph == RUN);
        e.f  = (m_ph == FAULT);
        e.rc = m_retry[RW-1:0];
        e.lc = m_lost[7:0];
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic lk, input logic sr);
        locked = lk;
        soft_reset_req = sr;
        @(posedge refclk);
        if (rst == 1'b0) model_reset();
        else model_edge(lk, sr);
        sb_q.push_back(model_out());
        #1;
    endtask

    // Asserted between edges: the pending expectation for this cycle is
    // replaced by the reset values, checked before the next edge.
    task automatic async_rst();
        rst = 1'b0;
        model_reset();
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        sb_q.push_back(model_out());
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge refclk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {state_o, pll_rst, sys_rst_n, fault, retry_cnt, lock_lost_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%0d pll_rst=%b sys_rst_n=%b fault=%b retry=%0d lost=%0d, expected st=%0d pll_rst=%b sys_rst_n=%b fault=%b retry=%0d lost=%0d",
                             $time, a.st, a.pr, a.sr, a.f, a.rc, a.lc,
                             e.st, e.pr, e.sr, e.f, e.rc, e.lc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int hi;
        int len;
        logic lk;

        model_reset();
        repeat (3) cycle(1'b0, 1'b0);
        rst = 1'b1;

        // first lock: locked rises 10 cycles after reset release
        repeat (10) cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0);

        // lock never returns: loss, then three timed-out attempts -> FAULT
        repeat (150) cycle(1'b0, 1'b0);

        // soft reset out of FAULT, then lock up again
        cycle(1'b0, 1'b1);
        repeat (25) cycle(1'b1, 1'b0);

        // short lock drops during the stable window
        repeat (20) begin
            cycle(1'b0, 1'b1);
            d  = $urandom_range(0, 12);
            hi = $urandom_range(3, 9);
            repeat (d) cycle(1'b0, 1'b0);
            repeat (hi) cycle(1'b1, 1'b0);
            repeat (3) cycle(1'b0, 1'b0);
            repeat (40) cycle(1'b1, 1'b0);
        end

        // repeated lock losses in RUN: counter must saturate at 255
        repeat (260) begin
            d = $urandom_range(1, 4);
            repeat (d) cycle(1'b0, 1'b0);
            repeat (25) cycle(1'b1, 1'b0);
        end

        // random lock glitches with occasional soft resets
        repeat (80) begin
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            repeat (len) cycle(lk, ($urandom_range(0, 59) == 0));
        end

        // asynchronous reset in the middle of the stable window
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 60 && m_ph != STABLE; i++) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        async_rst();
        repeat (2) cycle(1'b1, 1'b0);
        rst = 1'b1;
        repeat (20) cycle(1'b1, 1'b0);

        // asynchronous reset in the middle of the pll_rst pulse
        cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b1, 1'b0);
        async_rst();
        repeat (2) cycle(1'b1, 1'b0);
        rst = 1'b1;
        repeat (20) cycle(1'b1, 1'b0);

        @(negedge refclk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pll_lock_supervisor
`default_nettype wire
